// File: rtl/ss_upsizer.sv
// ss_upsizer: width up-converter for ss streams.
// Packs RATIO consecutive IN_BYTES-wide input beats into one output beat of
// IN_BYTES*RATIO bytes. The first accepted beat of a word lands in the MSBs.
// Packet boundaries are preserved: a short final word is zero-padded and two
// packets never share an output word.
//
// Optional feature: define SS_UPSIZER_KEEP_CHECK_EN to add the sticky `err`
// output that flags illegal keep patterns. The data path is identical either way.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   s_valid/s_ready    input handshake
//   s_data/s_keep      input beat, big-endian; keep only meaningful with s_last
//   s_last/s_user      end of packet, packet sideband
//   m_valid/m_ready    output handshake
//   m_data/m_keep      packed output word, big-endian
//   m_last/m_user      end of packet, packet sideband (taken from slot 0)
//   err                sticky keep-protocol error (SS_UPSIZER_KEEP_CHECK_EN only)
module ss_upsizer #(
  parameter int unsigned IN_BYTES  = 1,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned USER_BITS = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [IN_BYTES*8-1:0]           s_data,
  input  logic [IN_BYTES-1:0]             s_keep,
  input  logic                            s_last,
  input  logic [USER_BITS-1:0]            s_user,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [IN_BYTES*RATIO*8-1:0]     m_data,
  output logic [IN_BYTES*RATIO-1:0]       m_keep,
  output logic                            m_last,
`ifdef SS_UPSIZER_KEEP_CHECK_EN
  output logic                            err,
`endif
  output logic [USER_BITS-1:0]            m_user
);

  localparam int unsigned IN_W      = IN_BYTES * 8;
  localparam int unsigned OUT_BYTES = IN_BYTES * RATIO;
  localparam int unsigned OUT_W     = OUT_BYTES * 8;
  localparam int unsigned CNT_W     = $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  // Accumulator: slots written so far in the current word.
  logic [CNT_W-1:0]     r_cnt;
  logic [OUT_W-1:0]     r_acc_data;
  logic [OUT_BYTES-1:0] r_acc_keep;
  logic [USER_BITS-1:0] r_acc_user;

  // Output register stage.
  logic                 r_m_valid;
  logic [OUT_W-1:0]     r_m_data;
  logic [OUT_BYTES-1:0] r_m_keep;
  logic                 r_m_last;
  logic [USER_BITS-1:0] r_m_user;

  logic                 w_accept;
  logic                 w_complete;
  logic [IN_BYTES-1:0]  w_slot_keep;
  logic [OUT_W-1:0]     w_word_data;
  logic [OUT_BYTES-1:0] w_word_keep;
  logic [USER_BITS-1:0] w_word_user;

  // Input is accepted whenever the output register is empty or draining;
  // held low during reset so nothing is taken while the block is cleared.
  assign s_ready    = rst && (!r_m_valid || m_ready);
  assign w_accept   = s_valid && s_ready;
  assign w_complete = (r_cnt == CNT_LAST) || s_last;

  // Keep is only meaningful on the last beat; mid-packet slots are full.
  assign w_slot_keep = s_last ? s_keep : {IN_BYTES{1'b1}};

  // Accumulator with the current beat merged into slot r_cnt (slot 0 = MSBs).
  // Slots beyond r_cnt are still zero because the accumulator is cleared
  // after every completed word, which gives the zero padding for free.
  always_comb begin
    w_word_data = r_acc_data;
    w_word_keep = r_acc_keep;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_word_data[(RATIO-i)*IN_W-1 -: IN_W]         = s_data;
        w_word_keep[(RATIO-i)*IN_BYTES-1 -: IN_BYTES] = w_slot_keep;
      end
    end
  end

  // User is taken from the first beat of the word.
  assign w_word_user = (r_cnt == '0) ? s_user : r_acc_user;

  // Slot counter and accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_acc_data <= '0;
      r_acc_keep <= '0;
      r_acc_user <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_cnt      <= '0;
        r_acc_data <= '0;
        r_acc_keep <= '0;
        r_acc_user <= '0;
      end else begin
        r_cnt      <= r_cnt + CNT_W'(1);
        r_acc_data <= w_word_data;
        r_acc_keep <= w_word_keep;
        r_acc_user <= w_word_user;
      end
    end
  end

  // Output register: a completing beat loads it (even while draining, so
  // back-to-back words leave no bubble); otherwise a drain empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_m_user  <= '0;
    end else if (w_accept && w_complete) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_word_data;
      r_m_keep  <= w_word_keep;
      r_m_last  <= s_last;
      r_m_user  <= w_word_user;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_keep  = r_m_keep;
  assign m_last  = r_m_last;
  assign m_user  = r_m_user;

`ifdef SS_UPSIZER_KEEP_CHECK_EN
  logic [IN_BYTES-1:0] w_keep_inv;
  logic                w_keep_bad;
  logic                r_err;

  // Last-beat keep must be non-zero and a run of ones from the MSB, i.e. its
  // inverse must be a run of ones from the LSB (inv & (inv+1) == 0).
  assign w_keep_inv = ~s_keep;
  assign w_keep_bad = s_last ?
                      ((s_keep == '0) ||
                       ((w_keep_inv & (w_keep_inv + IN_BYTES'(1))) != '0)) :
                      (s_keep != {IN_BYTES{1'b1}});

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_accept && w_keep_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_ss_upsizer.sv
// Self-checking bench for ss_upsizer (IN_BYTES=1, RATIO=4, USER_BITS=1).
// A packet-level model turns each sent packet into the words it must yield;
// a negedge compare process checks every drained word, hold stability and
// s_ready. Directed tests add literal expectations on top.
module tb_ss_upsizer;

  localparam int unsigned IN_BYTES  = 1;
  localparam int unsigned RATIO     = 4;
  localparam int unsigned USER_BITS = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [0:0]  s_keep;
  logic        s_last;
  logic [0:0]  s_user;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic [0:0]  m_user;

  always #5 clk = ~clk;

`ifdef SS_UPSIZER_KEEP_CHECK_EN
  logic err1;
`endif

  ss_upsizer #(.IN_BYTES(IN_BYTES), .RATIO(RATIO), .USER_BITS(USER_BITS)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_last  (s_last),
    .s_user  (s_user),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
`ifdef SS_UPSIZER_KEEP_CHECK_EN
    .err     (err1),
`endif
    .m_user  (m_user)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] pkt[$];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Packet model: chop into 4-byte words, first byte in MSBs, zero-pad the tail.
  function automatic void model_pkt(input logic u);
    int    n;
    word_t w;
    n = pkt.size();
    for (int i = 0; i < n; i += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < n) begin
          w.d[31-8*j -: 8] = pkt[i+j];
          w.k[3-j]         = 1'b1;
        end
      end
      w.l = (i + 4 >= n);
      w.u = u;
      exp_q.push_back(w);
    end
  endfunction

  // Drive one beat starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic k,
                           input logic u, output int waits);
    logic got;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_keep  = k;
    s_user  = u;
    waits   = 0;
    forever begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      if (got) break;
      waits++;
      if (waits > 200) begin
        chk("beat_timeout", 64'(waits), 64'(0));
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  // Send pkt[] as one packet; junk=1 drives keep=0 on non-last beats.
  task automatic send_pkt(input logic u, input bit junk, output int stalls);
    int w;
    int n;
    n = pkt.size();
    model_pkt(u);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(pkt[i], (i == n - 1), (i == n - 1) ? 1'b1 : !junk, u, w);
      stalls += w;
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Compare process: s_ready rule, hold stability, drained words vs model.
  logic [38:0] prev_out;
  logic        prev_stall;
  logic        have_prev = 1'b0;
  word_t       e;

  always @(negedge clk) begin
    if (!rst) begin
      have_prev = 1'b0;
    end else begin
      chk("s_ready", 64'(s_ready), 64'(!m_valid || m_ready));
      if (have_prev && prev_stall)
        chk("hold", 64'({m_valid, m_data, m_keep, m_last, m_user}), 64'(prev_out));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 64'(m_data), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 64'(m_data), 64'(e.d));
          chk("word_keep", 64'(m_keep), 64'(e.k));
          chk("word_last", 64'(m_last), 64'(e.l));
          chk("word_user", 64'(m_user), 64'(e.u));
        end
      end
      prev_out   = {m_valid, m_data, m_keep, m_last, m_user};
      prev_stall = m_valid && !m_ready;
      have_prev  = 1'b1;
    end
  end

`ifdef SS_UPSIZER_KEEP_CHECK_EN
  logic        s2_valid;
  logic        s2_ready;
  logic [15:0] s2_data;
  logic [1:0]  s2_keep;
  logic        s2_last;
  logic [0:0]  s2_user;
  logic        m2_valid;
  logic [31:0] m2_data;
  logic [3:0]  m2_keep;
  logic        m2_last;
  logic [0:0]  m2_user;
  logic        err2;

  ss_upsizer #(.IN_BYTES(2), .RATIO(2), .USER_BITS(1)) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s2_valid),
    .s_ready (s2_ready),
    .s_data  (s2_data),
    .s_keep  (s2_keep),
    .s_last  (s2_last),
    .s_user  (s2_user),
    .m_valid (m2_valid),
    .m_ready (1'b1),
    .m_data  (m2_data),
    .m_keep  (m2_keep),
    .m_last  (m2_last),
    .err     (err2),
    .m_user  (m2_user)
  );

  // m_ready is tied high, so every offered beat is accepted at the next edge.
  task automatic send2(input logic [15:0] d, input logic l, input logic [1:0] k);
    s2_valid = 1'b1;
    s2_data  = d;
    s2_last  = l;
    s2_keep  = k;
    @(posedge clk);
    #1;
    s2_valid = 1'b0;
  endtask
`endif

  int st;

  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    s_user  = '0;
    m_ready = 1'b1;
`ifdef SS_UPSIZER_KEEP_CHECK_EN
    s2_valid = 1'b0;
    s2_data  = '0;
    s2_keep  = '0;
    s2_last  = 1'b0;
    s2_user  = '0;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data",  64'(m_data),  64'(0));
    chk("rst_m_keep",  64'(m_keep),  64'(0));
    chk("rst_m_last",  64'(m_last),  64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Four-byte packet: one full word, valid right after the last beat.
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(1'b0, 1'b0, st);
    chk("t1_valid", 64'(m_valid), 64'(1));
    chk("t1_data",  64'(m_data),  64'h11223344);
    chk("t1_keep",  64'(m_keep),  64'hF);
    chk("t1_last",  64'(m_last),  64'(1));
    chk("t1_stalls", 64'(st), 64'(0));

    // Six-byte packet then a three-byte packet back to back: no merging.
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(1'b0, 1'b0, st);
    chk("t2_data",  64'(m_data),  64'h55660000);
    chk("t2_keep",  64'(m_keep),  64'hC);
    pkt = '{8'h77, 8'h88, 8'h99};
    send_pkt(1'b1, 1'b0, st);
    chk("t2b_data", 64'(m_data),  64'h77889900);
    chk("t2b_keep", 64'(m_keep),  64'hE);

    // Single-byte packet with user set.
    pkt = '{8'hAB};
    send_pkt(1'b1, 1'b0, st);
    chk("t3_data", 64'(m_data), 64'hAB000000);
    chk("t3_keep", 64'(m_keep), 64'h8);
    chk("t3_last", 64'(m_last), 64'(1));
    chk("t3_user", 64'(m_user), 64'(1));
    drain();

    // Eight-byte packet with the first word stalled for 3 cycles.
    m_ready = 1'b0;
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    fork
      send_pkt(1'b0, 1'b0, st);
      begin
        int c;
        c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (!m_valid && c < 50);
        chk("t4_first_valid", 64'(m_valid), 64'(1));
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          chk("t4_stall_ready", 64'(s_ready), 64'(0));
          chk("t4_stall_data",  64'(m_data),  64'h01020304);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    chk("t4_total_stalls", 64'(st), 64'(3));
    drain();

    // Non-last keep of zero is ignored by the data path.
    pkt = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    send_pkt(1'b1, 1'b1, st);
    chk("t5_keep", 64'(m_keep), 64'h8);

    // Full rate: eight beats, no stall.
    pkt = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7, 8'hD8};
    send_pkt(1'b0, 1'b0, st);
    chk("t6_stalls", 64'(st), 64'(0));
    drain();

    // Reset after two of four bytes: partial word discarded.
    send_beat(8'hE1, 1'b0, 1'b1, 1'b0, st);
    send_beat(8'hE2, 1'b0, 1'b1, 1'b0, st);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_rst_valid", 64'(m_valid), 64'(0));
    chk("t7_rst_data",  64'(m_data),  64'(0));
    chk("t7_rst_keep",  64'(m_keep),  64'(0));
    chk("t7_rst_ready", 64'(s_ready), 64'(0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    pkt = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_pkt(1'b0, 1'b0, st);
    chk("t7_data", 64'(m_data), 64'hA1A2A3A4);
    chk("t7_keep", 64'(m_keep), 64'hF);
    drain();

`ifdef SS_UPSIZER_KEEP_CHECK_EN
    // Keep checker on a two-byte input instance.
    send2(16'h1234, 1'b0, 2'b11);
    send2(16'h5600, 1'b1, 2'b10);
    chk("err_legal", 64'(err2), 64'(0));
    send2(16'h1111, 1'b0, 2'b10);
    chk("err_set", 64'(err2), 64'(1));
    send2(16'h2222, 1'b1, 2'b11);
    chk("err_sticky", 64'(err2), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("err_rst", 64'(err2), 64'(0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ss_upsizer.md
# ss_upsizer

Width up-converter for ss streams. Packs RATIO consecutive IN_BYTES-wide input beats into one (IN_BYTES*RATIO)-wide output beat, preserving packet boundaries, big-endian byte order, keep and user. Sits directly downstream of narrow ss producers (byte-wide parsers, MAC receive path) and feeds wide packet-processing stages and FIFOs.

## Interface
- IN_BYTES, 1, bytes per input beat (>=1)
- RATIO, 4, input beats per output beat (>=2, power of two not required)
- USER_BITS, 1, width of packet sideband user
- clk  in  1  clock; all ports synchronous to rising edge
- rst  in  1  reset; asynchronous, active-low
- s_valid  in  1  input beat offered
- s_ready  out  1  upsizer accepts input beat this cycle
- s_data  in  IN_BYTES*8  input data, big-endian (byte 0 in MSBs)
- s_keep  in  IN_BYTES  input keep, big-endian; meaningful on last beat only
- s_last  in  1  last beat of packet
- s_user  in  USER_BITS  packet sideband
- m_valid  out  1  output beat offered
- m_ready  in  1  downstream accepts output beat
- m_data  out  IN_BYTES*RATIO*8  output data, first input beat in MSBs
- m_keep  out  IN_BYTES*RATIO  output keep, big-endian
- m_last  out  1  last beat of packet
- m_user  out  USER_BITS  packet sideband
- err  out  1  sticky keep-protocol error (only with SS_UPSIZER_KEEP_CHECK_EN)

## Operation
- Accumulator of RATIO slots, slot counter cnt (0..RATIO-1), plus one output register stage.
- Input beat accepted when s_valid && s_ready. Accepted beat written into slot cnt: slot 0 = MSBs.
- Slot keep = s_keep when s_last, else all ones.
- Completing beat: cnt == RATIO-1 or s_last. On completing beat, accumulator contents (including this beat) load output register; unfilled slots load data 0, keep 0; m_last = s_last; cnt returns to 0; accumulator cleared.
- Non-completing beat: cnt increments.
- m_user = s_user captured on slot 0 of the word (user constant within a packet by protocol).
- Packet with fewer than RATIO beats or non-multiple length: final word short, zero-padded; never merges two packets in one output word.
- s_ready = rst && (!m_valid || m_ready); applies to every input beat, completing or not.
- Output register holds data/keep/last/user stable while m_valid && !m_ready.
- m_valid clears on m_valid && m_ready unless a completing beat loads the register the same cycle (then stays 1 with new contents).

## Timing
- Reset (rst low, asynchronous): m_valid 0, m_data 0, m_keep 0, m_last 0, m_user 0, err 0, cnt 0, accumulator cleared; s_ready 0 while rst low.
- Latency: output word valid cycle after completing input beat accepted.
- Throughput: one input beat per cycle with m_ready held high; output rate 1 word per RATIO input beats.
- s_ready combinational from m_valid, m_ready; no dependence on s_valid.
- Simultaneous output drain and completing-beat load: new word in register next cycle, no bubble.
- Reset mid-packet: partial word discarded; next accepted beat treated as slot 0.
- m_ready low indefinitely: s_ready low, no input lost, no output change.

## Configuration
- SS_UPSIZER_KEEP_CHECK_EN defined: err port present; err set (sticky until reset) on accepted beat where s_last=0 and s_keep != all ones, or s_last=1 and s_keep is zero or not MSB-contiguous (e.g. 0b01 with IN_BYTES=2). Data path unaffected.
- Not defined: err port absent; no checking; non-last keep ignored as described.

## Test plan
- IN_BYTES=1, RATIO=4: 0x11,0x22,0x33,0x44 (last on 0x44), m_ready=1 -> one word 0x11223344, keep 0xF, last 1, m_valid one cycle after 0x44 accepted.
- 6-byte packet 0x11..0x66 -> 0x11223344 keep 0xF last 0, then 0x55660000 keep 0xC last 1; next packet starts in fresh word.
- Single-byte packet 0xAB, user 1 -> 0xAB000000 keep 0x8 last 1 user 1.
- Back-to-back 8-byte stream with m_ready low 3 cycles while word held -> s_ready low those cycles, m_data stable, no beat lost or duplicated; full rate when m_ready high.
- rst pulsed low after 2 of 4 bytes -> all outputs 0 immediately; following 4 bytes 0xA1..0xA4 last -> 0xA1A2A3A4 keep 0xF.
- With SS_UPSIZER_KEEP_CHECK_EN, IN_BYTES=2: non-last beat keep 0b10 -> err 1 next cycle, remains 1 until reset; legal traffic -> err stays 0.
